// File: rtl/prbs_pkg.sv
// Shared PRBS definitions used by the generator and by the downstream monitor.
// Holds the default polynomial, the seed, the FSM state type and a saturating-counter helper.
package prbs_pkg;

  localparam int         PRBS_WIDTH = 8;
  localparam logic [7:0] PRBS_TAPS  = 8'hB8;
  localparam logic [7:0] PRBS_SEED  = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RECOVER
  } prbs_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/prbs_generator_if.sv
// Control and data bundle between a PRBS generator and whoever drives it.
// The master drives control and seed; the slave (the generator) returns the word and status.
interface prbs_generator_if
  import prbs_pkg::*;
#(
  parameter int WIDTH = PRBS_WIDTH
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             inject_error;
  logic [IDX_W-1:0] inject_bit;
  logic [WIDTH-1:0] lfsr;
  logic             valid;
  logic             wrap;
  logic             lockup;
  logic [7:0]       err_count;

  modport master (
    output enable, load, seed, inject_error, inject_bit,
    input  lfsr, valid, wrap, lockup, err_count
  );

  modport slave (
    input  enable, load, seed, inject_error, inject_bit,
    output lfsr, valid, wrap, lockup, err_count
  );

endinterface

// File: rtl/prbs_next_state.sv
// One Fibonacci LFSR step with XNOR feedback; all-ones is the lockup word.
// Purely combinational so the monitor's predictor can reuse it unchanged.
module prbs_next_state
  import prbs_pkg::*;
#(
  parameter int               WIDTH = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = PRBS_TAPS
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  assign next_state = {state[WIDTH-2:0], ~^(state & TAPS)};

endmodule

// File: rtl/prbs_generator.sv
// PRBS source with seed load, run/hold, output-only error injection, wrap pulse
// and automatic recovery from the all-ones lockup word.
module prbs_generator
  import prbs_pkg::*;
#(
  parameter int               WIDTH = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = PRBS_TAPS,
  parameter logic [WIDTH-1:0] SEED  = PRBS_SEED
) (
  input  logic              clk,
  input  logic              rst,
  prbs_generator_if.slave   bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  prbs_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [7:0]       err_q, err_d;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] inj_mask;
  logic             inj_ok;

  prbs_next_state #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next (
    .state      (state_q),
    .next_state (next_word)
  );

  // Out-of-range bit indices are dropped rather than wrapped onto a valid bit.
  assign inj_ok   = bus.inject_error && (int'(bus.inject_bit) < WIDTH);
  assign inj_mask = inj_ok ? (ONE_HOT0 << bus.inject_bit) : '0;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    fsm_d    = fsm_q;
    state_d  = state_q;
    start_d  = start_q;
    lfsr_d   = lfsr_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = lockup_q;
    err_d    = err_q;

    if (bus.load) begin
      state_d  = bus.seed;
      start_d  = bus.seed;
      err_d    = '0;
      lockup_d = 1'b0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (bus.enable) fsm_d = RUN;
        end
        RUN: begin
          if (state_q == ALL_ONES) begin
            fsm_d    = RECOVER;
            state_d  = SEED;
            start_d  = SEED;
            lockup_d = 1'b1;
          end else if (bus.enable) begin
            state_d = next_word;
            lfsr_d  = next_word ^ inj_mask;
            valid_d = 1'b1;
            // Wrap looks at the clean word so injection can neither hide nor fake it.
            wrap_d  = (next_word == start_q);
            if (inj_ok) err_d = sat_inc8(err_q);
          end
        end
        RECOVER: begin
          fsm_d = RUN;
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q    <= IDLE;
      state_q  <= SEED;
      start_q  <= SEED;
      lfsr_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
      err_q    <= '0;
    end else begin
      // NOTE: registered state is updated with non-blocking assignments only.
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      start_q  <= start_d;
      lfsr_q   <= lfsr_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
      err_q    <= err_d;
    end
  end

  assign bus.lfsr      = lfsr_q;
  assign bus.valid     = valid_q;
  assign bus.wrap      = wrap_q;
  assign bus.lockup    = lockup_q;
  assign bus.err_count = err_q;

endmodule

// File: tb/tb_prbs_generator.sv
// Scoreboard bench for prbs_generator: stimulus queues expected words, a monitor
// checks every emitted word on the falling edge; directed checks use hand-computed constants.
module tb_prbs_generator;
  import prbs_pkg::*;

  localparam int W = PRBS_WIDTH;

  typedef struct packed {
    logic [7:0] word;
    logic       wrap;
    logic [7:0] err;
    logic       lockup;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  prbs_generator_if #(.WIDTH(W)) bus ();

  prbs_generator #(
    .WIDTH (W),
    .TAPS  (PRBS_TAPS),
    .SEED  (PRBS_SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks     = 0;
  int   errors     = 0;
  int   wraps_seen = 0;
  exp_t exp_q[$];

  prbs_state_e m_fsm;
  logic [7:0]  m_state, m_start, m_lfsr, m_err;
  logic        m_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Independent step: taps 7,5,4,3 XNORed into bit 0.
  function automatic logic [7:0] ref_next(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

  task automatic model_reset();
    m_fsm   = IDLE;
    m_state = PRBS_SEED;
    m_start = PRBS_SEED;
    m_lfsr  = 8'h00;
    m_err   = 8'h00;
    m_lock  = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic ld, input logic [7:0] sd,
                            input logic inj, input logic [2:0] ib, output logic emit);
    logic [7:0] nxt, word;
    exp_t e;
    emit = 1'b0;
    if (ld) begin
      m_state = sd;
      m_start = sd;
      m_err   = 8'h00;
      m_lock  = 1'b0;
    end else begin
      case (m_fsm)
        IDLE: if (en) m_fsm = RUN;
        RUN: begin
          if (m_state == 8'hFF) begin
            m_fsm   = RECOVER;
            m_state = PRBS_SEED;
            m_start = PRBS_SEED;
            m_lock  = 1'b1;
          end else if (en) begin
            nxt  = ref_next(m_state);
            word = nxt;
            if (inj) begin
              word[ib] = ~word[ib];
              if (m_err != 8'hFF) m_err = m_err + 8'd1;
            end
            e.wrap   = (nxt == m_start);
            e.word   = word;
            e.err    = m_err;
            e.lockup = m_lock;
            m_state  = nxt;
            m_lfsr   = word;
            exp_q.push_back(e);
            emit = 1'b1;
          end
        end
        default: m_fsm = RUN;
      endcase
    end
  endtask

  task automatic tick(input logic en, input logic ld, input logic [7:0] sd,
                      input logic inj, input logic [2:0] ib);
    logic emit;
    bus.enable       = en;
    bus.load         = ld;
    bus.seed         = sd;
    bus.inject_error = inj;
    bus.inject_bit   = ib;
    model_edge(en, ld, sd, inj, ib, emit);
    @(posedge clk);
    #1;
    check("valid", 32'(bus.valid), 32'(emit));
  endtask

  task automatic do_reset();
    check("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
    rst              = 1'b1;
    bus.enable       = 1'b0;
    bus.load         = 1'b0;
    bus.seed         = 8'h00;
    bus.inject_error = 1'b0;
    bus.inject_bit   = 3'd0;
    model_reset();
    #1;
    check("rst_lfsr",   32'(bus.lfsr),      32'h00);
    check("rst_valid",  32'(bus.valid),     32'd0);
    check("rst_wrap",   32'(bus.wrap),      32'd0);
    check("rst_lockup", 32'(bus.lockup),    32'd0);
    check("rst_errcnt", 32'(bus.err_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.valid === 1'b1) begin
        if (bus.wrap === 1'b1) wraps_seen++;
        if (exp_q.size() == 0) begin
          check("valid_without_expect", 32'(bus.valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_word",   32'(bus.lfsr),      32'(e.word));
          check("sb_wrap",   32'(bus.wrap),      32'(e.wrap));
          check("sb_errcnt", 32'(bus.err_count), 32'(e.err));
          check("sb_lockup", 32'(bus.lockup),    32'(e.lockup));
        end
      end else begin
        check("wrap_without_valid", 32'(bus.wrap), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: run exceeded time limit at t=%0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] first_words [5];
    first_words[0] = 8'h01;
    first_words[1] = 8'h03;
    first_words[2] = 8'h07;
    first_words[3] = 8'h0F;
    first_words[4] = 8'h1E;

    bus.enable       = 1'b0;
    bus.load         = 1'b0;
    bus.seed         = 8'h00;
    bus.inject_error = 1'b0;
    bus.inject_bit   = 3'd0;
    #1;

    // First words and two-edge latency
    do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
      check("first_words", 32'(bus.lfsr), 32'(first_words[i]));
    end

    // Wrap at emissions 255 and 510; injection on the wrap word keeps Wrap
    for (int n = 6; n <= 510; n++) begin
      tick(1'b1, 1'b0, 8'h00, n == 510, 3'd7);
      if (n == 255) begin
        check("wrap255_word", 32'(bus.lfsr), 32'h00);
        check("wrap255_flag", 32'(bus.wrap), 32'd1);
      end
    end
    check("wrap510_word", 32'(bus.lfsr),      32'h80);
    check("wrap510_flag", 32'(bus.wrap),      32'd1);
    check("wrap510_err",  32'(bus.err_count), 32'd1);
    @(negedge clk);
    #1;
    check("wrap_count", 32'(wraps_seen), 32'd2);

    // Injection on the 3rd emission, then saturation
    do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b1, 3'd0);
    check("inj_word",   32'(bus.lfsr),      32'h06);
    check("inj_errcnt", 32'(bus.err_count), 32'd1);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("post_inj_word", 32'(bus.lfsr), 32'h0F);
    for (int n = 0; n < 256; n++) tick(1'b1, 1'b0, 8'h00, 1'b1, 3'd2);
    check("err_saturated", 32'(bus.err_count), 32'hFF);

    // Load all-ones: lockup, recovery, restart from seed
    tick(1'b1, 1'b1, 8'hFF, 1'b1, 3'd1);
    check("load_errcnt", 32'(bus.err_count), 32'd0);
    check("load_lockup", 32'(bus.lockup),    32'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("lockup_set", 32'(bus.lockup), 32'd1);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("recover_word",   32'(bus.lfsr),   32'h01);
    check("recover_lockup", 32'(bus.lockup), 32'd1);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("recover_word2", 32'(bus.lfsr), 32'h03);

    // Hold with Enable low; injections there are dropped
    tick(1'b0, 1'b0, 8'h00, 1'b1, 3'd1);
    check("hold_word1", 32'(bus.lfsr), 32'h03);
    tick(1'b0, 1'b0, 8'h00, 1'b1, 3'd1);
    check("hold_word2",  32'(bus.lfsr),      32'h03);
    check("hold_errcnt", 32'(bus.err_count), 32'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("resume_word", 32'(bus.lfsr),   32'h07);
    check("hold_lockup", 32'(bus.lockup), 32'd1);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("resume_word2", 32'(bus.lfsr), 32'h0F);

    // A fresh Load clears Lockup
    tick(1'b1, 1'b1, 8'h00, 1'b0, 3'd0);
    check("reload_lockup", 32'(bus.lockup), 32'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("reload_word", 32'(bus.lfsr), 32'h01);

    // Asynchronous reset while Valid is high
    #5;
    check("valid_before_reset", 32'(bus.valid), 32'd1);
    do_reset();
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 3'd0);
    check("post_reset_word", 32'(bus.lfsr), 32'h01);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
